// File: rtl/psx_pkg.sv
// rtl/psx_pkg.sv - shared states, status codes and command bytes for the PSX port host
package psx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    BIT_LO,
    BIT_HI,
    ACK_WAIT,
    GAP
  } psx_state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_EMPTY   = 2'b10;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/psx_host_if.sv
// rtl/psx_host_if.sv - PSX controller-port pins seen from the host and from the controller
interface psx_host_if;
  logic psx_clk;
  logic cmd;
  logic att;
  logic data;
  logic ack;

  modport master (output psx_clk, output cmd, output att, input data, input ack);
  modport slave  (input psx_clk, input cmd, input att, output data, output ack);
endinterface

// File: rtl/psx_sync2.sv
// rtl/psx_sync2.sv - two-flop synchronizer for asynchronous controller inputs
module psx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/psx_host.sv
// rtl/psx_host.sv - PSX controller-port master running one att-framed transaction per start
module psx_host
  import psx_pkg::*;
#(
  parameter int MAX_BYTES   = 9,
  parameter int HALF_PERIOD = 4,
  parameter int ATT_SETUP   = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int ATT_GAP     = 16,
  localparam int NB_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NB_W-1:0]        n_bytes,
  input  logic [8*MAX_BYTES-1:0] tx_bytes,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic [8*MAX_BYTES-1:0] rx_bytes,
  output logic [NB_W-1:0]        rx_count,
  psx_host_if.master             psx
);

  localparam int T_MAX = max2(max2(HALF_PERIOD, ATT_SETUP), max2(ACK_TIMEOUT, ATT_GAP));
  localparam int TW    = $clog2(T_MAX + 1);

  psx_state_e             state, state_n;
  logic [TW-1:0]          timer, timer_n;
  logic [2:0]             bit_idx, bit_n;
  logic [NB_W-1:0]        byte_idx, byte_n;
  logic [NB_W-1:0]        nb, nb_n;
  logic [8*MAX_BYTES-1:0] tx_q, tx_n;
  logic [7:0]             shreg, sh_n;
  logic [8*MAX_BYTES-1:0] rx_n;
  logic [NB_W-1:0]        rxc_n;
  logic                   ack_seen, ack_seen_n;
  logic                   busy_n, done_n;
  logic [1:0]             status_n;
  logic                   psx_clk_n, cmd_n, att_n;
  logic [NB_W+2:0]        bit_pos;

  logic data_s, ack_s, ack_d, ack_rise;

  psx_sync2 u_sync_data (.clk(clk), .rst(rst), .d(psx.data), .q(data_s));
  psx_sync2 u_sync_ack  (.clk(clk), .rst(rst), .d(psx.ack),  .q(ack_s));

  assign ack_rise = ack_s & ~ack_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      nb          <= '0;
      tx_q        <= '0;
      shreg       <= '0;
      rx_bytes    <= '0;
      rx_count    <= '0;
      ack_seen    <= 1'b0;
      ack_d       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= ST_OK;
      psx.psx_clk <= 1'b1;
      psx.cmd     <= 1'b1;
      psx.att     <= 1'b1;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_idx     <= bit_n;
      byte_idx    <= byte_n;
      nb          <= nb_n;
      tx_q        <= tx_n;
      shreg       <= sh_n;
      rx_bytes    <= rx_n;
      rx_count    <= rxc_n;
      ack_seen    <= ack_seen_n;
      ack_d       <= ack_s;
      busy        <= busy_n;
      done        <= done_n;
      status      <= status_n;
      psx.psx_clk <= psx_clk_n;
      psx.cmd     <= cmd_n;
      psx.att     <= att_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer + 1'b1;
    bit_n      = bit_idx;
    byte_n     = byte_idx;
    nb_n       = nb;
    tx_n       = tx_q;
    sh_n       = shreg;
    rx_n       = rx_bytes;
    rxc_n      = rx_count;
    ack_seen_n = ack_seen | ack_rise;
    busy_n     = busy;
    done_n     = 1'b0;
    status_n   = status;

    case (state)
      IDLE: begin
        timer_n = '0;
        if (start) begin
          if (n_bytes == '0) begin
            done_n   = 1'b1;
            status_n = ST_EMPTY;
          end else begin
            state_n = SETUP;
            busy_n  = 1'b1;
            nb_n    = (n_bytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : n_bytes;
            tx_n    = tx_bytes;
            rx_n    = '0;
            rxc_n   = '0;
            byte_n  = '0;
            bit_n   = '0;
          end
        end
      end

      SETUP: begin
        if (timer == TW'(ATT_SETUP - 1)) begin
          state_n    = BIT_LO;
          timer_n    = '0;
          ack_seen_n = ack_rise;
        end
      end

      BIT_LO: begin
        if (timer == TW'(HALF_PERIOD - 1)) begin
          state_n = BIT_HI;
          timer_n = '0;
        end
      end

      BIT_HI: begin
        if (timer == TW'(HALF_PERIOD - 1)) begin
          timer_n = '0;
          sh_n    = {data_s, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            rx_n[{byte_idx, 3'b000} +: 8] = sh_n;
            rxc_n = rx_count + 1'b1;
            bit_n = '0;
            if (byte_idx == nb - 1'b1) begin
              state_n  = GAP;
              status_n = ST_OK;
              done_n   = 1'b1;
            end else begin
              state_n = ACK_WAIT;
            end
          end else begin
            bit_n   = bit_idx + 1'b1;
            state_n = BIT_LO;
          end
        end
      end

      ACK_WAIT: begin
        // ack_seen may already be set by an ack that arrived during the byte itself
        if (ack_seen) begin
          state_n    = BIT_LO;
          timer_n    = '0;
          byte_n     = byte_idx + 1'b1;
          ack_seen_n = ack_rise;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          state_n  = GAP;
          timer_n  = '0;
          status_n = ST_TIMEOUT;
          done_n   = 1'b1;
        end
      end

      GAP: begin
        if (timer == TW'(ATT_GAP - 1)) begin
          state_n = IDLE;
          timer_n = '0;
          busy_n  = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase

    bit_pos   = {byte_n, bit_n};
    psx_clk_n = (state_n != BIT_LO);
    att_n     = (state_n == IDLE) || (state_n == GAP);
    cmd_n     = 1'b1;
    if (state_n == BIT_LO || state_n == BIT_HI) cmd_n = tx_n[bit_pos];
  end

endmodule

// File: tb/tb_psx_host.sv
// tb/tb_psx_host.sv - randomized bench for psx_host against a behavioural controller model
module tb_psx_host;
  import psx_pkg::*;

  localparam int MAX_BYTES   = 9;
  localparam int HP          = 2;
  localparam int ATT_SETUP   = 8;
  localparam int ACK_TIMEOUT = 64;
  localparam int ATT_GAP     = 16;
  localparam int NB_W        = $clog2(MAX_BYTES + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [NB_W-1:0]        n_bytes = '0;
  logic [8*MAX_BYTES-1:0] tx_bytes = '0;
  logic                   busy, done;
  logic [1:0]             status;
  logic [8*MAX_BYTES-1:0] rx_bytes;
  logic [NB_W-1:0]        rx_count;

  psx_host_if psx ();

  psx_host #(
    .MAX_BYTES(MAX_BYTES), .HALF_PERIOD(HP), .ATT_SETUP(ATT_SETUP),
    .ACK_TIMEOUT(ACK_TIMEOUT), .ATT_GAP(ATT_GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_bytes(n_bytes), .tx_bytes(tx_bytes),
    .busy(busy), .done(done), .status(status), .rx_bytes(rx_bytes),
    .rx_count(rx_count), .psx(psx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // controller model: stimulus set by tasks, observations written only by the monitor
  logic [7:0] reply   [MAX_BYTES];
  bit         ack_en  [MAX_BYTES];
  bit         early_ack = 1'b0;
  logic [7:0] cmd_cap [MAX_BYTES];
  int cyc = 0, dev_byte = 0, dev_bit = 0;
  int n_falls = 0, att_falls = 0, done_cnt = 0;
  int done_cyc = 0, busy_low_cyc = 0, last_rise_cyc = 0, r07_cyc = 0, f10_cyc = 0;
  int ack_on_cyc = -1, ack_off_cyc = -1;
  bit prev_clk = 1'b1, prev_att = 1'b1, prev_busy = 1'b0;

  always @(posedge clk) begin
    #1;
    if (cyc == 0) psx.ack = 1'b0;
    cyc++;
    if (cyc == ack_off_cyc) psx.ack = 1'b0;
    if (cyc == ack_on_cyc) begin
      psx.ack     = 1'b1;
      ack_off_cyc = cyc + 2;
    end
    if (prev_clk && !psx.psx_clk) n_falls++;
    if (psx.att) begin
      dev_byte = 0;
      dev_bit  = 0;
      psx.data = 1'b1;
    end else begin
      if (prev_clk && !psx.psx_clk) begin
        if (dev_byte == 1 && dev_bit == 0) f10_cyc = cyc;
        if (dev_byte < MAX_BYTES) psx.data = reply[dev_byte][dev_bit];
        if (early_ack && dev_byte == 0 && dev_bit == 7) ack_on_cyc = cyc + 1;
      end
      if (!prev_clk && psx.psx_clk) begin
        last_rise_cyc = cyc;
        if (dev_byte < MAX_BYTES) cmd_cap[dev_byte][dev_bit] = psx.cmd;
        if (dev_bit == 7) begin
          if (dev_byte == 0) r07_cyc = cyc;
          if (dev_byte < MAX_BYTES && ack_en[dev_byte] && !(early_ack && dev_byte == 0))
            ack_on_cyc = cyc + int'($urandom_range(1, 8));
          dev_bit = 0;
          dev_byte++;
        end else begin
          dev_bit++;
        end
      end
    end
    if (prev_att && !psx.att) att_falls++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_busy && !busy) busy_low_cyc = cyc;
    prev_clk  = psx.psx_clk;
    prev_att  = psx.att;
    prev_busy = busy;
  end

  task automatic run_frame(input int n, input int ack_stop, input bit early,
                           input bit restart, input bit rnd);
    int nb, exp_cnt, waited, b_falls, b_att, b_done, d;
    logic [1:0] exp_st;
    logic [8*MAX_BYTES-1:0] exp_rx, exp_cmd, got_cmd, tx_save;
    nb = (n > MAX_BYTES) ? MAX_BYTES : n;
    if (rnd) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        tx_bytes[8*i +: 8] = 8'($urandom);
        reply[i]           = 8'($urandom);
      end
    end
    for (int i = 0; i < MAX_BYTES; i++) ack_en[i] = (i != ack_stop) && (i < nb - 1);
    early_ack = early;
    tx_save   = tx_bytes;
    b_falls   = n_falls;
    b_att     = att_falls;
    b_done    = done_cnt;
    @(negedge clk);
    n_bytes = NB_W'(n);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_high", busy, 1);
    if (restart) begin
      repeat (40) @(negedge clk);
      start    = 1'b1;
      n_bytes  = NB_W'(3);
      tx_bytes = ~tx_bytes;
      @(negedge clk);
      start = 1'b0;
    end
    waited = 0;
    while (!(done_cnt > b_done && !busy) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("frame_end", waited < 5000, 1);
    repeat (3) @(negedge clk);

    exp_cnt = nb;
    exp_st  = ST_OK;
    for (int i = 0; i < nb - 1; i++) begin
      if (!ack_en[i]) begin
        exp_cnt = i + 1;
        exp_st  = ST_TIMEOUT;
        break;
      end
    end
    exp_rx  = '0;
    exp_cmd = '0;
    got_cmd = '0;
    for (int i = 0; i < exp_cnt; i++) begin
      exp_rx[8*i +: 8]  = reply[i];
      exp_cmd[8*i +: 8] = tx_save[8*i +: 8];
      got_cmd[8*i +: 8] = cmd_cap[i];
    end
    check("status", status, exp_st);
    check("rx_count", rx_count, exp_cnt);
    check("rx_bytes", rx_bytes, exp_rx);
    check("clk_falls", n_falls - b_falls, 8 * exp_cnt);
    check("cmd_stream", got_cmd, exp_cmd);
    check("done_pulses", done_cnt - b_done, 1);
    check("att_frames", att_falls - b_att, 1);
    check("att_idle", psx.att, 1);
    check("clk_idle", psx.psx_clk, 1);
    check("cmd_idle", psx.cmd, 1);
    check("gap_len", busy_low_cyc - done_cyc, ATT_GAP);
    if (exp_st == ST_TIMEOUT) begin
      d = done_cyc - last_rise_cyc;
      check("timeout_win", (d >= ACK_TIMEOUT) && (d <= ACK_TIMEOUT + HP + 2), 1);
    end
    if (early && exp_cnt > 1) check("early_ack_gap", f10_cyc - r07_cyc, HP + 1);
  endtask

  task automatic run_empty();
    int b_att, b_done;
    b_att  = att_falls;
    b_done = done_cnt;
    @(negedge clk);
    n_bytes = '0;
    start   = 1'b1;
    @(posedge clk);
    #2;
    check("empty_done", done, 1);
    check("empty_status", status, ST_EMPTY);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("empty_one_done", done_cnt - b_done, 1);
    check("empty_no_att", att_falls - b_att, 0);
    check("empty_hold", status, ST_EMPTY);
  endtask

  task automatic run_reset();
    int waited, b_done;
    for (int i = 0; i < MAX_BYTES; i++) begin
      tx_bytes[8*i +: 8] = 8'($urandom);
      reply[i]           = 8'($urandom);
      ack_en[i]          = (i < 4);
    end
    early_ack = 1'b0;
    @(negedge clk);
    n_bytes = NB_W'(5);
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (!(dev_byte == 2 && dev_bit == 3 && !psx.psx_clk) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("rst_reach", waited < 2000, 1);
    b_done = done_cnt;
    rst    = 1'b1;
    @(posedge clk);
    #2;
    check("rst_att", psx.att, 1);
    check("rst_clk", psx.psx_clk, 1);
    check("rst_cmd", psx.cmd, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_done", done_cnt - b_done, 0);
  endtask

  initial begin
    int n, nb, stop;
    bit early;
    repeat (4) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_status", status, ST_OK);
    check("reset_rx_count", rx_count, 0);
    check("reset_rx_bytes", rx_bytes, 0);
    check("reset_clk", psx.psx_clk, 1);
    check("reset_cmd", psx.cmd, 1);
    check("reset_att", psx.att, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tx_bytes        = '0;
    tx_bytes[7:0]   = CMD_START;
    tx_bytes[15:8]  = CMD_POLL;
    reply[0] = 8'hFF; reply[1] = 8'h41; reply[2] = 8'h5A; reply[3] = 8'h00; reply[4] = 8'hFF;
    for (int i = 5; i < MAX_BYTES; i++) reply[i] = 8'h00;
    run_frame(5, -1, 1'b0, 1'b0, 1'b0);
    run_frame(5, 1, 1'b0, 1'b0, 1'b0);
    run_frame(5, -1, 1'b1, 1'b0, 1'b0);
    run_empty();
    run_frame(12, -1, 1'b0, 1'b0, 1'b1);
    run_reset();
    run_frame(5, -1, 1'b0, 1'b0, 1'b1);
    run_frame(4, -1, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 8; k++) begin
      n     = int'($urandom_range(1, 12));
      nb    = (n > MAX_BYTES) ? MAX_BYTES : n;
      stop  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      early = (stop != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame(n, stop, early, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psx_host.md
Name: psx_host

Overview:
Parametrised PSX controller-port host (master) that runs one complete att-framed transaction per start pulse. It clocks out up to MAX_BYTES command bytes LSB-first on cmd and simultaneously shifts in reply bytes from data. It waits for the controller's ack between bytes and reports the result with a status code. It replaces the fixed two-command/three-byte poller with configurable length, timing, ack timeout and error reporting.

Parameters:
MAX_BYTES, 9, maximum bytes per transaction (covers digital, analog and config frames)
HALF_PERIOD, 4, clk cycles per psx_clk half-period (>=2)
ATT_SETUP, 8, clk cycles from att falling to first psx_clk falling edge
ACK_TIMEOUT, 64, clk cycles allowed after a byte's last rising edge for ack to arrive
ATT_GAP, 16, clk cycles att is held high after a transaction before busy drops

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only when busy=0
n_bytes  in  NB_W=$clog2(MAX_BYTES+1)  byte count, latched on accepted start
tx_bytes  in  8*MAX_BYTES  command bytes; byte i at [8i+7:8i]; latched on start
busy  out  1  high from accepted start until the end of the ATT_GAP period
done  out  1  one-cycle pulse when a transaction ends
status  out  2  valid with done and held until the next start: 00 ok, 01 ack timeout, 10 empty request
rx_bytes  out  8*MAX_BYTES  received bytes, same packing as tx_bytes; unreceived bytes are 00
rx_count  out  NB_W  number of complete bytes received
psx_clk  out  1  controller clock; idles high
cmd  out  1  command line; idles high
att  out  1  attention, active low; idles high
data  in  1  controller reply (asynchronous)
ack  in  1  controller acknowledge, active-high pulse (asynchronous)

Behaviour:
- Reset values: busy=0, done=0, status=00, rx_bytes=0, rx_count=0, psx_clk=1, cmd=1, att=1. A reset mid-transaction aborts it at the next edge. There is no done pulse on reset.
- data and ack each pass through a 2-flop synchronizer. Ack detection uses the rising edge of the synchronized ack.
- FSM states: IDLE, SETUP, BIT_LO, BIT_HI, ACK_WAIT, GAP.
- IDLE: on start with n_bytes=0, pulse done next cycle with status=10. att is not asserted.
- IDLE: on start with n_bytes>0, latch inputs and clamp n_bytes to MAX_BYTES. Set att=0, clear rx, and go to SETUP.
- SETUP: wait ATT_SETUP cycles, then go to BIT_LO.
- BIT_LO: psx_clk=0. cmd takes the current tx bit on entry. Hold for HALF_PERIOD cycles.
- BIT_HI: psx_clk=1 for HALF_PERIOD cycles. The synchronized data is shifted into the byte MSB (LSB-first order) on the final cycle of this state.
- After bit 7, the byte is written to rx_bytes and rx_count increments.
- If the byte was the last one, go to GAP with status=00.
- Otherwise go to ACK_WAIT. cmd returns high.
- ack_seen is cleared at each byte's first BIT_LO. An ack edge seen at any point during the byte counts, so an early ack is not lost.
- ACK_WAIT: advance to the next byte's BIT_LO as soon as ack_seen is set (minimum one cycle in this state).
- ACK_WAIT: if ACK_TIMEOUT cycles elapse without an ack, go to GAP with status=01.
- GAP: att=1, cmd=1, psx_clk=1. done pulses on entry. busy drops after ATT_GAP cycles.
- start while busy is ignored. tx_bytes and n_bytes changes while busy have no effect.
- Counters: bit counter 3 bits, byte index NB_W bits, timer sized for max(HALF_PERIOD, ATT_SETUP, ACK_TIMEOUT, ATT_GAP).

Decomposition:
- Package psx_pkg holds: state enum, status codes (ST_OK, ST_TIMEOUT, ST_EMPTY), common PSX command bytes (CMD_START=8'h01, CMD_POLL=8'h42).
- One sub-module, psx_sync2: a 2-flop synchronizer, instantiated for data and ack.

Test Plan:
- HALF_PERIOD=2, n_bytes=5, tx=01 42 00 00 00; model replies FF 41 5A 00 FF and acks bytes 0-3 -> rx_bytes=FF 41 5A 00 FF, rx_count=5, status=00, exactly 40 psx_clk falls, cmd bitstream LSB-first matches tx.
- Same frame, model withholds ack after byte 1 -> status=01 after ACK_TIMEOUT cycles, rx_count=2, att high, no further psx_clk edges.
- Ack asserted during bit 7 of byte 0 (early) -> accepted; byte 1 starts one cycle into ACK_WAIT; status=00.
- n_bytes=0 -> done one cycle after start, status=10, att never falls. n_bytes=12 with MAX_BYTES=9 -> exactly 9 bytes clocked.
- rst asserted in byte 2 bit 3 -> next edge att=1, psx_clk=1, cmd=1, busy=0, rx_count=0, no done; a new start then runs a clean frame.
- Second start pulsed while busy -> ignored; only one done pulse, and att low for exactly one frame.
